serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor computing a - b over WIDTH-bit operands, LSB first, one bit per clock.
- Each bit step is the subtract counterpart of the half-adder cell: two chained half-subtractors producing a difference bit and a borrow.
- Used where a full parallel subtractor is too costly. A start/busy/done handshake frames each operation.

---
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b processed LSB first, one bit per clock.
// Start/busy/done handshake; diff/borrow update only when an operation completes.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;

  logic ai, bi, hs1_d, hs1_b, dbit, hs2_b, br_next;

  // Two chained half-subtractors: ai - bi, then minus the running borrow.
  always_comb begin
    ai      = a_q[0];
    bi      = b_q[0];
    hs1_d   = ai ^ bi;
    hs1_b   = ~ai & bi;
    dbit    = hs1_d ^ br_q;
    hs2_b   = ~hs1_d & br_q;
    br_next = hs1_b | hs2_b;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d             = a_q >> 1;
        b_d             = b_q >> 1;
        res_d           = res_q >> 1;
        res_d[WIDTH-1]  = dbit;
        br_d            = br_next;
        cnt_d           = cnt_q + CW'(1);
        // Final bit: publish the completed result on the same edge that enters DONE.
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = res_d;
          borrow_d = br_next;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, scoreboard of expected
// results, and hand-written sequences for held start, mid-run reset and WIDTH=1.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow;
  logic [W-1:0] diff;

  logic start1 = 1'b0;
  logic a1 = 1'b0, b1 = 1'b0;
  logic busy1, done1, diff1, borrow1;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [W:0] sb[$];
  logic [W-1:0] last_d = '0;
  logic         last_b = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
  } vec_t;
  vec_t vecs[5];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending result.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_busy_excl", 32'(busy), 32'd0);
      check("done_one_cycle", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] exp;
        exp = sb.pop_front();
        check("result", 32'({diff, borrow}), 32'(exp));
      end
    end
    prev_done = done;
  end

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb);
    int busy_n = 0;
    int lat = 0;
    bit seen = 0;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    sb.push_back({ed, eb});
    @(posedge clk);
    #1 start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        seen = 1;
        lat = k;
      end else begin
        check("hold_diff", 32'(diff), 32'(last_d));
        check("hold_borrow", 32'(borrow), 32'(last_b));
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(W + 1));
    check("busy_cycles", 32'(busy_n), 32'(W));
    last_d = ed;
    last_b = eb;
  endtask

  task automatic do_op1(input logic av, input logic bv, input logic ed, input logic eb);
    int busy_n = 0;
    int lat = 0;
    bit seen = 0;
    @(negedge clk);
    a1 = av; b1 = bv; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    a1 = ~av; b1 = ~bv;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      if (busy1) busy_n++;
      if (done1) begin
        seen = 1;
        lat = k;
        check("w1_diff", 32'(diff1), 32'(ed));
        check("w1_borrow", 32'(borrow1), 32'(eb));
      end
    end
    check("w1_done_seen", 32'(seen), 32'd1);
    check("w1_latency", 32'(lat), 32'd2);
    check("w1_busy_cycles", 32'(busy_n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    vecs[0] = '{a: 8'h5A, b: 8'h23, d: 8'h37, br: 1'b0};
    vecs[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, br: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'h01, d: 8'hFF, br: 1'b1};
    vecs[3] = '{a: 8'h80, b: 8'h80, d: 8'h00, br: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'hFF, d: 8'h01, br: 1'b1};

    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br);

    // Start held high: three back-to-back operations, operands disturbed mid-run.
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    repeat (3) sb.push_back({8'h0F, 1'b0});
    d0 = done_cnt;
    for (int s = 1; s <= 30; s++) begin
      @(negedge clk);
      if (s % 10 == 3) begin a = 8'hFF; b = 8'hFF; end
      if (s % 10 == 8) begin a = 8'h10; b = 8'h01; end
      if (s == 30) start = 1'b0;
    end
    repeat (12) @(negedge clk);
    check("held_done_count", 32'(done_cnt - d0), 32'd3);
    check("held_sb_empty", 32'(sb.size()), 32'd0);
    last_d = 8'h0F;
    last_b = 1'b0;

    // Reset during the 4th RUN cycle aborts the operation.
    @(negedge clk);
    a = 8'h5A; b = 8'h23; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_borrow", 32'(borrow), 32'd0);
    last_d = '0;
    last_b = 1'b0;
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    check("idle_after_rst", 32'(busy), 32'd0);
    do_op(8'h09, 8'h04, 8'h05, 1'b0);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    do_op1(1'b0, 1'b1, 1'b1, 1'b1);
    do_op1(1'b1, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
